sensor_event_queue: RTL

//  Converts level flags from the sensor sub-tops (gyro, touch, sonic, joystick) into discrete,

---
 rtl/sensor_evt_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/sensor_event_queue.sv | 113 +++++++++++
 3 files changed

// File: rtl/sensor_evt_pkg.sv
// Shared event codes and helpers for the sensor event queue.
// Codes are the bit index of the originating sensor flag.
package sensor_evt_pkg;

  localparam int unsigned NUM_SRC    = 8;
  localparam int unsigned EVT_CODE_W = 3;

  typedef enum logic [EVT_CODE_W-1:0] {
    EVT_AWAKING   = 3'd0,
    EVT_TOUCHED   = 3'd1,
    EVT_EXPECTING = 3'd2,
    EVT_PRESSED   = 3'd3,
    EVT_UP        = 3'd4,
    EVT_DOWN      = 3'd5,
    EVT_LEFT      = 3'd6,
    EVT_RIGHT     = 3'd7
  } evt_code_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [EVT_CODE_W-1:0] lowest_index(input logic [NUM_SRC-1:0] mask);
    logic [EVT_CODE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (mask[i]) idx = EVT_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers for full/empty detection.
// Head data reads as zero while empty; pop on empty and push on full without pop are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;

  assign pop_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/sensor_event_queue.sv
// Turns sensor level flags into rate-limited event codes queued for screen_top.
// Optional SEQ_TIMESTAMP_EN stores a free-running timestamp with each event.
module sensor_event_queue
  import sensor_evt_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned HOLDOFF_CYCLES = 5_000_000,
  parameter int unsigned TS_W           = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             sensor_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [2:0]             evt_code,
  output logic [TS_W-1:0]        evt_ts,
  output logic [$clog2(DEPTH):0] evt_level,
  output logic                   evt_overflow
);

  localparam int unsigned HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES);

`ifdef SEQ_TIMESTAMP_EN
  localparam int unsigned FW = EVT_CODE_W + TS_W;
`else
  localparam int unsigned FW = EVT_CODE_W;
`endif

  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] rise, accepted, cand;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [HO_W-1:0]    holdoff_q [NUM_SRC];
  logic [HO_W-1:0]    holdoff_d [NUM_SRC];
  logic               overflow_q, overflow_d;
  evt_code_e          push_code;
  logic               push, pop, push_ok;
  logic               fifo_full, fifo_empty;
  logic [FW-1:0]      push_data, pop_data;

  assign rise = sensor_in & ~prev_q;

  always_comb begin
    accepted = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      accepted[i]  = rise[i] && (holdoff_q[i] == '0);
      holdoff_d[i] = holdoff_q[i];
      if (accepted[i])               holdoff_d[i] = HO_LOAD;
      else if (holdoff_q[i] != '0)   holdoff_d[i] = holdoff_q[i] - HO_W'(1);
    end
  end

  // Lowest candidate goes to the FIFO; everything else waits in pending.
  always_comb begin
    cand       = pending_q | accepted;
    pop        = evt_valid & evt_ready;
    push_ok    = ~fifo_full | pop;
    push       = (cand != '0) && push_ok;
    push_code  = evt_code_e'(lowest_index(cand));
    pending_d  = cand;
    if (push) pending_d[push_code] = 1'b0;
    overflow_d = overflow_q | ((accepted & pending_q) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '1;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) holdoff_q[i] <= '0;
    end else begin
      prev_q     <= sensor_in;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_SRC; i++) holdoff_q[i] <= holdoff_d[i];
    end
  end

`ifdef SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign push_data = {ts_q, push_code};
  assign evt_ts    = pop_data[FW-1:EVT_CODE_W];
`else
  assign push_data = push_code;
  assign evt_ts    = '0;
`endif

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (pop_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (evt_level)
  );

  assign evt_valid    = ~fifo_empty;
  assign evt_code     = pop_data[EVT_CODE_W-1:0];
  assign evt_overflow = overflow_q;

endmodule
